// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a word-addressed data memory and
// configurable wait states. Freezes upstream while an access is in flight and
// registers results into the MEM/WB boundary.
// Optional macro MEM_ERR_EN adds a registered mem_err pulse for out-of-range
// or misaligned accesses (misaligned accesses are then dropped / read as 0).
module mem_stage #(
    parameter int WORD_LEN    = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic                WB_en_in,
    input  logic [4:0]          dest_in,
    input  logic [WORD_LEN-1:0] ALU_res,
    input  logic [WORD_LEN-1:0] ST_value,
    output logic                freeze,
    output logic [WORD_LEN-1:0] ALU_res_out,
    output logic [WORD_LEN-1:0] MEM_result_out,
    output logic [4:0]          dest_out,
    output logic                WB_en_out,
    output logic                MEM_R_EN_out
`ifdef MEM_ERR_EN
    ,
    output logic                mem_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 3) ? $clog2(WAIT_CYCLES + 1) : 2;

    localparam logic [WORD_LEN-1:0] LP_BASE     = WORD_LEN'(BASE_ADDR);
    localparam logic [WORD_LEN-1:0] LP_DEPTH    = WORD_LEN'(DEPTH);
    localparam logic [CNT_W-1:0]    LP_CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    logic                w_mem_op;
    logic                w_load;
    logic                w_freeze;
    logic                w_access;
    logic                w_bubble;

    logic [WORD_LEN-1:0] w_word;
    logic [IDX_W-1:0]    w_idx;
    logic                w_in_range;
    logic                w_addr_ok;

    logic [WORD_LEN-1:0] r_mem [DEPTH];

    logic [WORD_LEN-1:0] r_alu_res;
    logic [WORD_LEN-1:0] r_mem_result;
    logic [4:0]          r_dest;
    logic                r_wb_en;
    logic                r_mem_r_en;

    // A simultaneous read and write request is a store.
    assign w_mem_op = MEM_R_EN | MEM_W_EN;
    assign w_load   = MEM_R_EN & ~MEM_W_EN;

    // Full-width word offset so that anything below BASE_ADDR (which wraps to a
    // huge value) or past the array end fails the range check.
    assign w_word     = (ALU_res - LP_BASE) >> 2;
    assign w_idx      = w_word[IDX_W-1:0];
    assign w_in_range = (ALU_res >= LP_BASE) && (w_word < LP_DEPTH);

`ifdef MEM_ERR_EN
    assign w_addr_ok = w_in_range && (ALU_res[1:0] == 2'b00);
`else
    assign w_addr_ok = w_in_range;
`endif

    assign freeze = w_freeze;

    // Wait-state FSM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, freeze, completion strobe and bubble control.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_freeze     = 1'b0;
        w_access     = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access = 1'b1;
                    end else begin
                        w_freeze     = 1'b1;
                        w_bubble     = 1'b1;
                        w_cnt_next   = LP_CNT_LOAD;
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_freeze   = 1'b1;
                    w_bubble   = 1'b1;
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_access     = w_mem_op;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Data memory write port; contents survive reset, but reset cancels a
    // store completing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && w_access && MEM_W_EN && w_addr_ok) begin
            r_mem[w_idx] <= ST_value;
        end
    end

    // MEM/WB boundary register; a bubble clears only the write-back controls.
    // Load data is read before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_res    <= '0;
            r_mem_result <= '0;
            r_dest       <= '0;
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
        end else if (w_bubble) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
        end else begin
            r_alu_res    <= ALU_res;
            r_dest       <= dest_in;
            r_wb_en      <= WB_en_in;
            r_mem_r_en   <= w_load;
            r_mem_result <= (w_access && w_load && w_addr_ok) ? r_mem[w_idx] : '0;
        end
    end

`ifdef MEM_ERR_EN
    logic r_mem_err;

    // One-cycle error flag following a completed bad-address access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_access && !w_addr_ok;
        end
    end

    assign mem_err = r_mem_err;
`endif

    assign ALU_res_out    = r_alu_res;
    assign MEM_result_out = r_mem_result;
    assign dest_out       = r_dest;
    assign WB_en_out      = r_wb_en;
    assign MEM_R_EN_out   = r_mem_r_en;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage. Instance A uses two
// wait states, instance B none. Each stimulus cycle pushes the hand-computed
// freeze and visible MEM/WB outputs; per-instance monitors pop and compare.
module tb_mem_stage;

    typedef struct {
        logic        frz;
        logic [31:0] alu;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    exp_t qA[$];
    exp_t qB[$];

    logic        rstA, mrA, mwA, wbA, frzA, wboA, mroA;
    logic [4:0]  dA, doA;
    logic [31:0] aA, sA, aoA, roA;
    logic        rstB, mrB, mwB, wbB, frzB, wboB, mroB;
    logic [4:0]  dB, doB;
    logic [31:0] aB, sB, aoB, roB;
`ifdef MEM_ERR_EN
    logic        errA, errB;
`endif

    always #5 clk = ~clk;

    mem_stage #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rstA), .MEM_R_EN(mrA), .MEM_W_EN(mwA), .WB_en_in(wbA),
        .dest_in(dA), .ALU_res(aA), .ST_value(sA), .freeze(frzA),
        .ALU_res_out(aoA), .MEM_result_out(roA), .dest_out(doA),
        .WB_en_out(wboA), .MEM_R_EN_out(mroA)
`ifdef MEM_ERR_EN
        , .mem_err(errA)
`endif
    );

    mem_stage #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rstB), .MEM_R_EN(mrB), .MEM_W_EN(mwB), .WB_en_in(wbB),
        .dest_in(dB), .ALU_res(aB), .ST_value(sB), .freeze(frzB),
        .ALU_res_out(aoB), .MEM_result_out(roB), .dest_out(doB),
        .WB_en_out(wboB), .MEM_R_EN_out(mroB)
`ifdef MEM_ERR_EN
        , .mem_err(errB)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (qA.size() != 0) begin
            e = qA.pop_front();
            chk("A.freeze", 32'(frzA), 32'(e.frz));
            chk("A.ALU_res_out", aoA, e.alu);
            chk("A.MEM_result_out", roA, e.res);
            chk("A.dest_out", 32'(doA), 32'(e.dest));
            chk("A.WB_en_out", 32'(wboA), 32'(e.wb));
            chk("A.MEM_R_EN_out", 32'(mroA), 32'(e.mr));
`ifdef MEM_ERR_EN
            chk("A.mem_err", 32'(errA), 32'(e.err));
`endif
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (qB.size() != 0) begin
            e = qB.pop_front();
            chk("B.freeze", 32'(frzB), 32'(e.frz));
            chk("B.ALU_res_out", aoB, e.alu);
            chk("B.MEM_result_out", roB, e.res);
            chk("B.dest_out", 32'(doB), 32'(e.dest));
            chk("B.WB_en_out", 32'(wboB), 32'(e.wb));
            chk("B.MEM_R_EN_out", 32'(mroB), 32'(e.mr));
`ifdef MEM_ERR_EN
            chk("B.mem_err", 32'(errB), 32'(e.err));
`endif
        end
    end

    // One cycle: drive inputs, push expected freeze for this cycle and the
    // outputs that should be visible during it.
    task automatic step(input bit which, input logic r, mr, mw, wb,
                        input logic [4:0] d, input logic [31:0] a, s,
                        input logic frz, input logic [31:0] ea, er,
                        input logic [4:0] ed, input logic ew, em, ee);
        exp_t e;
        @(posedge clk);
        #1;
        e.frz = frz; e.alu = ea; e.res = er; e.dest = ed;
        e.wb = ew; e.mr = em; e.err = ee;
        if (which == 1'b0) begin
            rstA = r; mrA = mr; mwA = mw; wbA = wb; dA = d; aA = a; sA = s;
            qA.push_back(e);
        end else begin
            rstB = r; mrB = mr; mwB = mw; wbB = wb; dB = d; aB = a; sB = s;
            qB.push_back(e);
        end
    endtask

    // Two-wait-state access on instance A: freeze for two cycles, the first
    // cycle shows the previous result, the frozen cycles show a bubble.
    task automatic acc(input logic mr, mw, wb, input logic [4:0] d,
                       input logic [31:0] a, s, pa, pr,
                       input logic [4:0] pd, input logic pw, pm, pe);
        step(1'b0, 1'b0, mr, mw, wb, d, a, s, 1'b1, pa, pr, pd, pw, pm, pe);
        step(1'b0, 1'b0, mr, mw, wb, d, a, s, 1'b1, pa, pr, pd, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, mr, mw, wb, d, a, s, 1'b0, pa, pr, pd, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstA = 1'b1; mrA = 1'b0; mwA = 1'b0; wbA = 1'b0; dA = '0; aA = '0; sA = '0;
        rstB = 1'b1; mrB = 1'b0; mwB = 1'b0; wbB = 1'b0; dB = '0; aB = '0; sB = '0;
        repeat (2) @(posedge clk);

        // Instance A: reset state, then pass-through non-memory op.
        step(0, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd3, 32'd7, 32'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
        //   mr mw wb dest   addr      data           prev alu     prev res       pd    pw pm pe
        acc(0, 1, 0, 5'd0,  32'd1028, 32'hDEADBEEF, 32'd7,       32'h0,        5'd3,  1, 0, 0);
        acc(1, 0, 1, 5'd5,  32'd1028, 32'h0,        32'h404,     32'h0,        5'd0,  0, 0, 0);
        acc(0, 1, 0, 5'd0,  32'd1024, 32'h11111111, 32'h404,     32'hDEADBEEF, 5'd5,  1, 1, 0);
        acc(0, 1, 0, 5'd0,  32'd1276, 32'h63636363, 32'h400,     32'h0,        5'd0,  0, 0, 0);
        acc(0, 1, 0, 5'd0,  32'd1020, 32'hBAD0BAD0, 32'h4FC,     32'h0,        5'd0,  0, 0, 0);
        acc(0, 1, 0, 5'd0,  32'd1280, 32'hBAD1BAD1, 32'h3FC,     32'h0,        5'd0,  0, 0, 1);
        acc(1, 0, 1, 5'd7,  32'd1020, 32'h0,        32'h500,     32'h0,        5'd0,  0, 0, 1);
        acc(1, 0, 1, 5'd8,  32'd1280, 32'h0,        32'h3FC,     32'h0,        5'd7,  1, 1, 1);
        acc(1, 0, 1, 5'd9,  32'd1024, 32'h0,        32'h500,     32'h0,        5'd8,  1, 1, 1);
        acc(1, 0, 1, 5'd10, 32'd1276, 32'h0,        32'h400,     32'h11111111, 5'd9,  1, 1, 0);
        acc(0, 1, 0, 5'd0,  32'd1040, 32'hAAAA5555, 32'h4FC,     32'h63636363, 5'd10, 1, 1, 0);

        // Reset lands on the completion cycle of a store: store must be lost.
        step(0, 0, 0, 1, 0, 5'd0, 32'd1040, 32'h12345678, 1, 32'h410, 32'h0, 5'd0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 5'd0, 32'd1040, 32'h12345678, 1, 32'h410, 32'h0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 5'd0, 32'd1040, 32'h12345678, 0, 32'h410, 32'h0, 5'd0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 5'd0, 32'd0,    32'h0,        0, 32'h0,   32'h0, 5'd0, 0, 0, 0);

        acc(1, 0, 1, 5'd11, 32'd1040, 32'h0,        32'h0,       32'h0,        5'd0,  0, 0, 0);
        acc(1, 0, 1, 5'd12, 32'd1028, 32'h0,        32'h410,     32'hAAAA5555, 5'd11, 1, 1, 0);
        // Read and write together behave as a store.
        acc(1, 1, 0, 5'd0,  32'd1048, 32'd5,        32'h404,     32'hDEADBEEF, 5'd12, 1, 1, 0);
        acc(1, 0, 1, 5'd13, 32'd1048, 32'h0,        32'h418,     32'h0,        5'd0,  0, 0, 0);
        step(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'h418, 32'd5, 5'd13, 1, 1, 0);
        step(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'h0,   32'h0, 5'd0,  0, 0, 0);

        // Instance B: zero wait states, back-to-back accesses, no freeze.
        step(1, 1, 0, 0, 0, 5'd0, 32'd0,    32'h0,        0, 32'h0,   32'h0,        5'd0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 5'd0, 32'd1024, 32'hA0A0A0A0, 0, 32'h0,   32'h0,        5'd0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 5'd0, 32'd1032, 32'hB1B1B1B1, 0, 32'h400, 32'h0,        5'd0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 5'd1, 32'd1024, 32'h0,        0, 32'h408, 32'h0,        5'd0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 5'd2, 32'd1032, 32'h0,        0, 32'h400, 32'hA0A0A0A0, 5'd1, 1, 1, 0);
        step(1, 0, 1, 0, 1, 5'd3, 32'd1280, 32'h0,        0, 32'h408, 32'hB1B1B1B1, 5'd2, 1, 1, 0);
        step(1, 0, 0, 0, 0, 5'd0, 32'd0,    32'h0,        0, 32'h500, 32'h0,        5'd3, 1, 1, 1);
        step(1, 0, 0, 0, 0, 5'd0, 32'd0,    32'h0,        0, 32'h0,   32'h0,        5'd0, 0, 0, 0);

        repeat (2) @(posedge clk);
        if (qA.size() != 0 || qB.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", qA.size() + qB.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Consumes the ALU result, used as a byte address, and the forwarded store value. Performs loads and stores on a word-addressed data memory with a configurable wait-state latency.
- Drives a freeze to the upstream pipeline while an access is in progress.
- Registers its results into the MEM/WB boundary for write-back.

Parameters:
- WORD_LEN, 32, data and address width.
- DEPTH, 64, number of data memory words (power of 2).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, freeze cycles per memory access (0 allowed).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- WB_en_in  in  1  write-back enable of the instruction.
- dest_in  in  5  destination register.
- ALU_res  in  WORD_LEN  address, or ALU result for non-memory instructions.
- ST_value  in  WORD_LEN  store data.
- freeze  out  1  combinational stall to IF/ID/EXE and their pipeline registers.
- ALU_res_out  out  WORD_LEN  registered ALU_res.
- MEM_result_out  out  WORD_LEN  registered load data.
- dest_out  out  5  registered dest_in.
- WB_en_out  out  1  registered write-back enable.
- MEM_R_EN_out  out  1  registered load flag, used as the WB mux select.

Behaviour:
- Address mapping: idx = (ALU_res - BASE_ADDR) >> 2. Low 2 bits are ignored.
- Out-of-range address (ALU_res < BASE_ADDR or idx >= DEPTH):
  - stores are dropped;
  - loads return 0.
- MEM_W_EN and MEM_R_EN both high: treated as a store. MEM_R_EN_out=0 and MEM_result_out=0.
- FSM states are IDLE and BUSY. A 2-bit-or-wider counter cnt is sized for WAIT_CYCLES.
- IDLE, no memory op: freeze=0. The output register loads the pass-through values with MEM_result_out=0. The block has 1-cycle latency.
- IDLE, memory op, WAIT_CYCLES=0: freeze=0. The access completes this cycle:
  - store commits at the clock edge;
  - load data is registered into MEM_result_out at the same edge.
- IDLE, memory op, WAIT_CYCLES>0: freeze=1, cnt<=WAIT_CYCLES-1, next state BUSY. The output register loads a bubble.
- BUSY, cnt>0: freeze=1, cnt<=cnt-1, bubble loaded.
- BUSY, cnt==0: freeze=0. The access completes as in the WAIT_CYCLES=0 case, then next state IDLE.
- Access timing: an access presented at cycle T sees freeze high in cycles T..T+WAIT_CYCLES-1. It completes at the edge ending cycle T+WAIT_CYCLES. Results are visible from cycle T+WAIT_CYCLES+1.
- Bubble means WB_en_out=0 and MEM_R_EN_out=0. The other output registers hold their previous values. No duplicate write-back occurs.
- Upstream holds all inputs stable while freeze=1. The block samples address and data only in the completion cycle.
- A load always reads memory before any same-edge write. Only one access completes per cycle.
- Back-to-back memory ops are allowed: the next op enters IDLE the cycle after completion, and each costs WAIT_CYCLES+1 cycles.
- Memory is synchronous write. Load data is read from the array and registered at completion; there is no separate read latency.
- Reset, including mid-access:
  - FSM goes to IDLE and cnt is 0;
  - all registered outputs are 0;
  - freeze is 0 in the cycle after reset deasserts, unless a new op is present;
  - a pending store is discarded;
  - memory array contents are retained, not cleared.

Optional Feature:
- Macro MEM_ERR_EN.
- Defined:
  - adds output mem_err (1 bit, registered, reset 0);
  - mem_err pulses high for exactly one cycle, the cycle after a completed access whose address is out of range or not word-aligned (ALU_res[1:0]!=0);
  - a misaligned store is dropped;
  - a misaligned load returns 0.
- Undefined: the port does not exist, and misaligned addresses are silently truncated to the word (low 2 bits ignored).

Test Plan:
- WAIT_CYCLES=2. Store ST_value=32'hDEADBEEF to ALU_res=1028, then load from 1028:
  - freeze is high exactly 2 cycles per access;
  - the load yields MEM_result_out=32'hDEADBEEF with MEM_R_EN_out=1 and WB_en_out=1 for one cycle;
  - every freeze cycle is a bubble.
- Non-memory op ALU_res=7, dest_in=3, WB_en_in=1 → next cycle ALU_res_out=7, dest_out=3, WB_en_out=1, freeze never asserted.
- WAIT_CYCLES=0, back-to-back stores to 1024 and 1032 then loads → no freeze, data 1:1 next cycle each.
- Out-of-range:
  - store to 1020 and to 1024+4*DEPTH is dropped, with no other word changed;
  - load from either returns 0;
  - with MEM_ERR_EN, mem_err=1 for one cycle each.
- rst asserted in BUSY during a store to 1040 → outputs 0, FSM IDLE. A later load of 1040 returns the pre-reset old value, and other memory words are unchanged.
- MEM_R_EN=MEM_W_EN=1, ALU_res=1048, ST_value=5 → word written 5, MEM_R_EN_out=0, MEM_result_out=0.
